// File: rtl/reg_bus_arbiter_if.sv
// Requester, register-file and status signals of the shared register port.
// The slave modport is the arbiter's view; master is the environment's view.
interface reg_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 32
);
    logic              i_a_req;
    logic              i_a_we;
    logic [ADDR_W-1:0] i_a_addr;
    logic [DATA_W-1:0] i_a_wdata;
    logic              o_a_ack;
    logic              o_a_err;
    logic [DATA_W-1:0] o_a_rdata;

    logic              i_b_req;
    logic              i_b_we;
    logic [ADDR_W-1:0] i_b_addr;
    logic [DATA_W-1:0] i_b_wdata;
    logic              o_b_ack;
    logic              o_b_err;
    logic [DATA_W-1:0] o_b_rdata;

    logic              o_reg_en;
    logic              o_reg_we;
    logic [ADDR_W-1:0] o_reg_addr;
    logic [DATA_W-1:0] o_reg_wdata;
    logic [DATA_W-1:0] i_reg_rdata;
    logic              i_reg_ready;
    logic              o_busy;

    modport slave (
        input  i_a_req, i_a_we, i_a_addr, i_a_wdata,
        output o_a_ack, o_a_err, o_a_rdata,
        input  i_b_req, i_b_we, i_b_addr, i_b_wdata,
        output o_b_ack, o_b_err, o_b_rdata,
        output o_reg_en, o_reg_we, o_reg_addr, o_reg_wdata,
        input  i_reg_rdata, i_reg_ready,
        output o_busy
    );

    modport master (
        output i_a_req, i_a_we, i_a_addr, i_a_wdata,
        input  o_a_ack, o_a_err, o_a_rdata,
        output i_b_req, i_b_we, i_b_addr, i_b_wdata,
        input  o_b_ack, o_b_err, o_b_rdata,
        input  o_reg_en, o_reg_we, o_reg_addr, o_reg_wdata,
        output i_reg_rdata, i_reg_ready,
        input  o_busy
    );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register-file port between requesters A and B,
// one transaction in flight, with a slave-ready timeout that returns an error.
module reg_bus_arbiter #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          TIMEOUT  = 16,
    parameter logic [DATA_W-1:0]    ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic               clk,
    input  logic               i_reset,
    reg_bus_arbiter_if.slave   bus
);
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t            state;
    logic              last_b;
    logic              win_b;
    logic              tmo;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] cap;

    logic              a_req;
    logic              b_req;
    logic              pick_b;
    logic [DATA_W-1:0] resp_data;

    // A requester still showing its ack has not yet had a chance to drop req.
    always_comb begin
        a_req  = bus.i_a_req & ~bus.o_a_ack;
        b_req  = bus.i_b_req & ~bus.o_b_ack;
        pick_b = b_req & (~a_req | ~last_b);
        if (tmo) begin
            resp_data = ERR_DATA;
        end else if (bus.o_reg_we) begin
            resp_data = '0;
        end else begin
            resp_data = cap;
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= IDLE;
            last_b          <= 1'b1;
            win_b           <= 1'b0;
            tmo             <= 1'b0;
            cnt             <= '0;
            cap             <= '0;
            bus.o_a_ack     <= 1'b0;
            bus.o_a_err     <= 1'b0;
            bus.o_a_rdata   <= '0;
            bus.o_b_ack     <= 1'b0;
            bus.o_b_err     <= 1'b0;
            bus.o_b_rdata   <= '0;
            bus.o_reg_en    <= 1'b0;
            bus.o_reg_we    <= 1'b0;
            bus.o_reg_addr  <= '0;
            bus.o_reg_wdata <= '0;
            bus.o_busy      <= 1'b0;
        end else begin
            bus.o_a_ack <= 1'b0;
            bus.o_b_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (a_req | b_req) begin
                        win_b           <= pick_b;
                        bus.o_reg_we    <= pick_b ? bus.i_b_we : bus.i_a_we;
                        bus.o_reg_addr  <= pick_b ? bus.i_b_addr : bus.i_a_addr;
                        bus.o_reg_wdata <= pick_b ? bus.i_b_wdata : bus.i_a_wdata;
                        bus.o_reg_en    <= 1'b1;
                        bus.o_busy      <= 1'b1;
                        cnt             <= '0;
                        tmo             <= 1'b0;
                        state           <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (bus.i_reg_ready) begin
                        cap          <= bus.i_reg_rdata;
                        bus.o_reg_en <= 1'b0;
                        state        <= RESP;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        tmo          <= 1'b1;
                        bus.o_reg_en <= 1'b0;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (win_b) begin
                        bus.o_b_ack   <= 1'b1;
                        bus.o_b_err   <= tmo;
                        bus.o_b_rdata <= resp_data;
                    end else begin
                        bus.o_a_ack   <= 1'b1;
                        bus.o_a_err   <= tmo;
                        bus.o_a_rdata <= resp_data;
                    end
                    last_b     <= win_b;
                    bus.o_busy <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    bus.o_reg_en <= 1'b0;
                    bus.o_busy   <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end
endmodule
